// File: rtl/wb_pkg.sv
// Shared write-back stage types: source select, load size, default widths.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_REGW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

endpackage

// File: rtl/wb_load_ext.sv
// Load data alignment and sign/zero extension by size and byte offset; purely combinational.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [OFFW-1:0] byte_off,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] lane;
    logic            sgn_b;
    logic            sgn_h;
    logic [XLEN-1:0] word_ext;

    assign lane  = mem_data >> {byte_off, 3'b000};
    assign sgn_b = ~ld_unsigned & lane[7];
    assign sgn_h = ~ld_unsigned & lane[15];

    // A word on a 32-bit datapath is already full width; only RV64 extends it.
    if (XLEN > 32) begin : g_word_ext
        logic sgn_w;
        assign sgn_w    = ~ld_unsigned & lane[31];
        assign word_ext = {{(XLEN - 32){sgn_w}}, lane[31:0]};
    end else begin : g_word_full
        assign word_ext = lane;
    end

    always_comb begin
        ld_data = lane;
        case (ld_size_e'(ld_size))
            LD_B:    ld_data = {{(XLEN - 8){sgn_b}}, lane[7:0]};
            LD_H:    ld_data = {{(XLEN - 16){sgn_h}}, lane[15:0]};
            LD_W:    ld_data = word_ext;
            default: ld_data = (XLEN > 32) ? lane : word_ext;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage, 1-cycle latency; holds the pending write while rf_busy (in_ready low).
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter; otherwise instret is 0.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NSRC = 4,
    parameter int REGW = WB_REGW,
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [SELW-1:0] wb_sel,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [OFFW-1:0] byte_off,
    input  logic [REGW-1:0] rd,
    input  logic            werf,
    input  logic            rf_busy,
    output logic [XLEN-1:0] wb_data,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_we,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [63:0]     instret
);

    logic            out_valid;
    logic            accept;
    logic [1:0]      sel2;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] sel_data;

    wb_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .mem_data    (mem_data),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .byte_off    (byte_off),
        .ld_data     (ld_data)
    );

    assign in_ready = ~out_valid | ~rf_busy;
    assign accept   = in_valid & in_ready & ~flush;
    assign wb_we    = out_valid & ~rf_busy;
    assign sel2     = 2'(wb_sel);

    // Selects beyond the configured source count fall back to the ALU result.
    always_comb begin
        sel_data = ex_result;
        if (int'(sel2) < NSRC) begin
            case (wb_sel_e'(sel2))
                WB_MEM:  sel_data = ld_data;
                WB_PC4:  sel_data = pc_plus4;
                WB_CSR:  sel_data = csr_rdata;
                default: sel_data = ex_result;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            wb_data   <= '0;
            wb_rd     <= '0;
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
        end else begin
            if (accept) begin
                out_valid <= werf & (rd != '0);
                wb_rd     <= rd;
                wb_data   <= sel_data;
            end else if (wb_we) begin
                out_valid <= 1'b0;
            end
            // History tracks committed writes only; flush never touches it.
            if (wb_we) begin
                fwd_valid <= 1'b1;
                fwd_rd    <= wb_rd;
                fwd_data  <= wb_data;
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (accept) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed-vector bench for wb_stage_pipe with a write scoreboard checked by an independent monitor.
module tb_wb_stage_pipe;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] ex_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
    logic [31:0] csr_rdata;
    logic [1:0]  wb_sel;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [1:0]  byte_off;
    logic [4:0]  rd;
    logic        werf;
    logic        rf_busy;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    wb_stage_pipe #(.XLEN(32), .NSRC(4), .REGW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ex_result(ex_result), .mem_data(mem_data), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
        .wb_sel(wb_sel), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
        .rd(rd), .werf(werf), .rf_busy(rf_busy), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] mem;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vt[12];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_instret = 64'd0;

    localparam logic [31:0] EX_DEF  = 32'h1111_1111;
    localparam logic [31:0] PC_DEF  = 32'h2222_2222;
    localparam logic [31:0] CSR_DEF = 32'h3333_3333;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] instret_model();
`ifdef WB_INSTRET_EN
        return exp_instret;
`else
        return 64'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [31:0] ex, input logic [31:0] mem,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [4:0] rd_i, input logic we);
        in_valid    = 1'b1;
        flush       = 1'b0;
        wb_sel      = sel;
        ex_result   = ex;
        mem_data    = mem;
        ld_size     = size;
        ld_unsigned = uns;
        byte_off    = off;
        rd          = rd_i;
        werf        = we;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Monitor: every write presented by the DUT must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wb_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", wb_rd, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_rd", 64'(wb_rd), 64'(e.rd));
                    chk("write_data", 64'(wb_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        // mem_data = 0x80FF_7F01 for all load rows
        vt[0]  = '{WB_MEM, 32'h80FF_7F01, LD_B, 1'b0, 2'd3, 5'd6,  32'hFFFF_FF80};
        vt[1]  = '{WB_MEM, 32'h80FF_7F01, LD_B, 1'b1, 2'd3, 5'd7,  32'h0000_0080};
        vt[2]  = '{WB_MEM, 32'h80FF_7F01, LD_H, 1'b0, 2'd2, 5'd8,  32'hFFFF_80FF};
        vt[3]  = '{WB_MEM, 32'h80FF_7F01, LD_H, 1'b1, 2'd2, 5'd9,  32'h0000_80FF};
        vt[4]  = '{WB_MEM, 32'h80FF_7F01, LD_B, 1'b0, 2'd0, 5'd10, 32'h0000_0001};
        vt[5]  = '{WB_MEM, 32'h80FF_7F01, LD_B, 1'b0, 2'd1, 5'd11, 32'h0000_007F};
        vt[6]  = '{WB_MEM, 32'h80FF_7F01, LD_W, 1'b0, 2'd0, 5'd12, 32'h80FF_7F01};
        vt[7]  = '{WB_MEM, 32'h80FF_7F01, LD_D, 1'b0, 2'd0, 5'd13, 32'h80FF_7F01};
        vt[8]  = '{WB_MEM, 32'h80FF_7F01, LD_B, 1'b0, 2'd2, 5'd14, 32'hFFFF_FFFF};
        vt[9]  = '{WB_PC4, 32'h80FF_7F01, LD_B, 1'b0, 2'd0, 5'd15, PC_DEF};
        vt[10] = '{WB_CSR, 32'h80FF_7F01, LD_B, 1'b0, 2'd0, 5'd16, CSR_DEF};
        vt[11] = '{WB_ALU, 32'h80FF_7F01, LD_B, 1'b0, 2'd0, 5'd17, EX_DEF};

        rst = 1'b1; rf_busy = 1'b0; pc_plus4 = PC_DEF; csr_rdata = CSR_DEF;
        issue(WB_ALU, EX_DEF, 32'h0, LD_B, 1'b0, 2'd0, 5'd0, 1'b0);
        idle();
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_fwd_rd", 64'(fwd_rd), 64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // First ALU write and its forwarding history
        tick(); issue(WB_ALU, 32'h1234_5678, 32'h0, LD_B, 1'b0, 2'd0, 5'd5, 1'b1);
        exp_q.push_back('{5'd5, 32'h1234_5678}); exp_instret++;
        @(negedge clk); chk("alu_in_ready", 64'(in_ready), 64'd1);
        tick(); idle();
        @(negedge clk); chk("alu_wb_we", 64'(wb_we), 64'd1);
        tick();
        @(negedge clk);
        chk("alu_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("alu_fwd_rd", 64'(fwd_rd), 64'd5);
        chk("alu_fwd_data", 64'(fwd_data), 64'h1234_5678);
        chk("alu_drained", 64'(wb_we), 64'd0);

        // Back-to-back entries covering every source and load shape
        for (int i = 0; i < 12; i++) begin
            tick();
            issue(vt[i].sel, EX_DEF, vt[i].mem, vt[i].size, vt[i].uns, vt[i].off, vt[i].rd, 1'b1);
            exp_q.push_back('{vt[i].rd, vt[i].exp}); exp_instret++;
            @(negedge clk);
            if (i > 0) chk("b2b_wb_we", 64'(wb_we), 64'd1);
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
        end
        tick(); idle();
        @(negedge clk); chk("b2b_last_we", 64'(wb_we), 64'd1);
        tick();
        @(negedge clk);
        chk("b2b_idle_we", 64'(wb_we), 64'd0);
        chk("b2b_fwd_rd", 64'(fwd_rd), 64'd17);
        chk("b2b_fwd_data", 64'(fwd_data), 64'(EX_DEF));
        chk("b2b_instret", instret, instret_model());

        // rd=0 and werf=0 retire without writing
        tick(); issue(WB_ALU, 32'hDEAD_0000, 32'h0, LD_B, 1'b0, 2'd0, 5'd0, 1'b1); exp_instret++;
        @(negedge clk);
        tick(); issue(WB_ALU, 32'hDEAD_0001, 32'h0, LD_B, 1'b0, 2'd0, 5'd3, 1'b0); exp_instret++;
        @(negedge clk); chk("x0_no_we", 64'(wb_we), 64'd0);
        tick(); idle();
        @(negedge clk);
        chk("nowerf_no_we", 64'(wb_we), 64'd0);
        chk("nowrite_instret", instret, instret_model());

        // rf_busy held 3 cycles on a pending write, then drain and accept together
        tick(); issue(WB_ALU, 32'hA5A5_0001, 32'h0, LD_B, 1'b0, 2'd0, 5'd20, 1'b1);
        exp_q.push_back('{5'd20, 32'hA5A5_0001}); exp_instret++;
        @(negedge clk);
        tick(); rf_busy = 1'b1;
        issue(WB_ALU, 32'h5A5A_0002, 32'h0, LD_B, 1'b0, 2'd0, 5'd21, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_wb_we", 64'(wb_we), 64'd0);
            chk("stall_wb_data", 64'(wb_data), 64'hA5A5_0001);
            chk("stall_wb_rd", 64'(wb_rd), 64'd20);
        end
        tick(); rf_busy = 1'b0;
        exp_q.push_back('{5'd21, 32'h5A5A_0002}); exp_instret++;
        @(negedge clk);
        chk("drain_wb_we", 64'(wb_we), 64'd1);
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("next_wb_we", 64'(wb_we), 64'd1);
        chk("next_wb_rd", 64'(wb_rd), 64'd21);

        // Flushed entry leaves no trace
        tick(); issue(WB_ALU, 32'hBAD0_0000, 32'h0, LD_B, 1'b0, 2'd0, 5'd22, 1'b1); flush = 1'b1;
        @(negedge clk); chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("flush_no_we", 64'(wb_we), 64'd0);
        chk("flush_fwd_rd", 64'(fwd_rd), 64'd21);
        chk("flush_fwd_data", 64'(fwd_data), 64'h5A5A_0002);
        chk("flush_instret", instret, instret_model());

        // Reset while a write is stalled discards it
        tick(); issue(WB_ALU, 32'hC0DE_0003, 32'h0, LD_B, 1'b0, 2'd0, 5'd23, 1'b1);
        @(negedge clk);
        tick(); idle(); rf_busy = 1'b1;
        @(negedge clk);
        chk("pend_wb_we", 64'(wb_we), 64'd0);
        chk("pend_wb_rd", 64'(wb_rd), 64'd23);
        tick(); rst = 1'b1;
        @(negedge clk);
        tick(); rst = 1'b0; rf_busy = 1'b0; exp_instret = 64'd0;
        @(negedge clk);
        chk("rst2_wb_we", 64'(wb_we), 64'd0);
        chk("rst2_wb_data", 64'(wb_data), 64'd0);
        chk("rst2_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst2_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst2_fwd_rd", 64'(fwd_rd), 64'd0);
        chk("rst2_fwd_data", 64'(fwd_data), 64'd0);
        chk("rst2_instret", instret, instret_model());
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        tick();
        @(negedge clk);
        chk("rst2_idle_we", 64'(wb_we), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Registered, parametrised write-back stage for the integer pipeline, sitting between the MEM/WB boundary and the register file. It selects among `NSRC` result sources and extends/aligns load data by size and byte offset. It holds a pending write when the register file write port is busy, and keeps a one-entry history of the last committed write for forwarding to decode. It replaces the purely combinational write-back mux with a stage that has real backpressure, x0 suppression and flush handling.

## Interface
Parameters:
- `XLEN`, 32, datapath width (32 or 64)
- `NSRC`, 4, number of write-back sources (2..4)
- `REGW`, 5, register index width

Ports (clock and reset are fixed: one clock; reset is synchronous and active-high):
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous active-high reset
- `in_valid` in 1, MEM/WB entry valid
- `in_ready` out 1, stage accepts entry this cycle
- `flush` in 1, kill the incoming entry this cycle
- `ex_result` in XLEN, ALU result (source 0)
- `mem_data` in XLEN, raw aligned load word (source 1)
- `pc_plus4` in XLEN, link address (source 2)
- `csr_rdata` in XLEN, CSR read data (source 3)
- `wb_sel` in clog2(NSRC), source select
- `ld_size` in 2, 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
- `ld_unsigned` in 1, zero-extend instead of sign-extend
- `byte_off` in clog2(XLEN/8), load byte offset within word
- `rd` in REGW, destination index
- `werf` in 1, instruction writes the register file
- `rf_busy` in 1, register file write port unavailable this cycle
- `wb_data` out XLEN, write data (registered)
- `wb_rd` out REGW, write index (registered)
- `wb_we` out 1, write enable
- `fwd_valid` / `fwd_rd` / `fwd_data` out 1 / REGW / XLEN, last committed write
- `instret` out 64, retired-instruction count (see Configuration)

## Operation
- Accept = `in_valid & in_ready & ~flush`. Flush with `in_valid` drops the entry; no state changes except `in_ready` is unaffected.
- `in_ready = ~out_valid | ~rf_busy` (the pending entry drains or the slot is empty).
- On accept: `out_valid <= werf & (rd != 0)`; `wb_rd <= rd`; `wb_data <= selected source`. An entry with `rd==0` or `werf==0` retires but produces no write.
- Source select: 0 ex_result, 1 extended load, 2 pc_plus4, 3 csr_rdata; any `wb_sel >= NSRC` selects ex_result.
- Load extension: lane = `mem_data >> (8*byte_off)`; width by `ld_size`; sign bit is the lane MSB unless `ld_unsigned`. `ld_size=10` on XLEN=32 passes the full word; `ld_size=11` on XLEN=32 is treated as 10. Misalignment is not checked (upstream traps).
- `wb_we = out_valid & ~rf_busy`. When a write completes and no new entry is accepted, `out_valid <= 0`.
- Forward history: on every cycle with `wb_we=1`, `fwd_valid<=1`, `fwd_rd<=wb_rd`, `fwd_data<=wb_data`. It holds until the next write and is never cleared by flush.

## Timing
- Latency is 1 cycle: an entry accepted at edge N drives `wb_we` during cycle N+1, unless `rf_busy` is asserted.
- `rf_busy` held k cycles stalls the pending write k cycles. `wb_data`/`wb_rd` stay stable while stalled and `in_ready=0`.
- Simultaneous drain and accept: the old write completes in the same cycle the new entry loads, giving back-to-back writes with no bubble.
- Reset values: `out_valid=0`, `wb_we=0`, `wb_data=0`, `wb_rd=0`, `fwd_valid=0`, `fwd_rd=0`, `fwd_data=0`, `instret=0`. `in_ready=1` the cycle after reset.
- Reset mid-stall discards the pending write; no write is issued.

## Configuration
- `WB_INSTRET_EN` defined: a 64-bit counter increments by 1 on each accept (regardless of `werf`/`rd`). It wraps from 2^64-1 to 0 and clears on reset.
- Not defined: no counter logic; `instret` is tied to 0.

## Structure
- Shared package `wb_pkg`: `wb_sel_e` (WB_ALU, WB_MEM, WB_PC4, WB_CSR), `ld_size_e` (LD_B, LD_H, LD_W, LD_D), default XLEN/REGW constants.
- One combinational sub-module `wb_load_ext` (size/offset/sign extension); all state lives in the top.

## Test plan
- Reset then accept {wb_sel=WB_ALU, ex_result=0x1234_5678, rd=5, werf=1} -> next cycle `wb_we=1`, `wb_rd=5`, `wb_data=0x1234_5678`; following cycle `fwd_rd=5`.
- Load byte mem_data=0x80FF_7F01, byte_off=3, signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080; half off=2 signed -> 0xFFFF_80FF.
- rd=0 with werf=1, or werf=0 -> `wb_we` never asserts; with `WB_INSTRET_EN`, `instret` increments by 1.
- Hold `rf_busy` 3 cycles with a pending write -> `in_ready=0` and `wb_we=0` for 3 cycles, data stable; write issues on the 4th cycle, and a new entry is accepted that same cycle.
- `flush=1` with `in_valid=1` -> no write, `instret` unchanged; back-to-back entries with rf_busy=0 -> one write per cycle.
- Assert `rst` while a write is pending under `rf_busy` -> no write issued; all outputs 0 next cycle.
